booth_mac_accumulator: RTL and testbench
========================================

// Module: booth_mac_accumulator
// PURPOSE
//  Downstream consumer of the 8x8 radix-4 Booth multiplier: accumulates a run of signed 16-bit
//  products into a signed ACC_W-bit sum, one dot product per run.
//  Runs are started by a command and close after a programmed number of products.
//  Overflow handling is wrap or saturate, selected by parameter. Result is held until next start.
// PARAMETERS
//  ACC_W   24  accumulator width in bits, signed; legal range 16..32
//  LEN_W   4   width of run-length field; run length is 1..2**LEN_W products
//  SAT_EN  1   1 = saturate on overflow; 0 = two's-complement wrap
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      begin new run; sampled every cycle
//  len         in   LEN_W  products in run, sampled with start; 0 means 2**LEN_W
//  prod        in   16     signed product from multiplier
//  prod_valid  in   1      prod is valid this cycle
//  prod_ready  out  1      block accepts prod this cycle
//  acc         out  ACC_W  signed running/final sum
//  done        out  1      one-cycle pulse: acc holds completed run result
//  busy        out  1      run in progress
//  ovf         out  1      sticky: overflow occurred in current/last run
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, acc=0, remaining=0, done=0, busy=0, ovf=0,
//    prod_ready=0.
//  - FSM states:
//    - IDLE:  start -> ACCUM.
//    - ACCUM: last product accepted -> DONE.
//    - DONE:  always exits after 1 cycle -> IDLE, or -> ACCUM if start is high in DONE.
//  - On start in any state:
//    - acc <= 0, ovf <= 0.
//    - remaining <= (len==0) ? 2**LEN_W : len.
//    - state <= ACCUM.
//  - start while in ACCUM aborts the run and restarts. Any prod handshake in that same cycle is
//    discarded.
//  - prod_ready = (state==ACCUM), driven combinationally from state only; it does not depend on
//    prod_valid.
//  - Accept = prod_valid & prod_ready & ~start. On accept:
//    - acc <= f(acc + sign-extend(prod) to ACC_W+1 bits);
//    - remaining <= remaining-1.
//  - Accept with remaining==1 -> next state DONE.
//  - prod_valid outside ACCUM is ignored; nothing is stored and no flag is set.
//  - Overflow: the ACC_W+1-bit sum does not fit in ACC_W bits.
//    - SAT_EN=1: clamp to +(2**(ACC_W-1)-1) or -(2**(ACC_W-1)), per sign of the true sum.
//    - SAT_EN=0: keep the low ACC_W bits.
//    - Either mode: ovf <= 1 and stays set until the next start or reset.
//  - Once saturated, later products continue accumulating from the clamped value.
//  - done=1 exactly in state DONE, i.e. the cycle after the final accept. acc is final and stable
//    from that cycle until the next start.
//  - busy=1 in ACCUM only.
//  - Latency: one accept per cycle maximum. An N-product run with no stalls gives done N+1 cycles
//    after start.
//  - Reset asserted mid-run: all state clears immediately and no done pulse is produced.
// TESTING
//  - start,len=3; prods 100,-50,1000 back-to-back -> acc=1050, done 1 cycle after 3rd accept,
//    ovf=0.
//  - start,len=0; 16 x prod=16384 (-128*-128) -> done after 16th accept, acc=262144 (0x040000),
//    ovf=0.
//  - ACC_W=16,SAT_EN=1; len=3, 3 x 16384 -> acc=32767, ovf=1.
//    Same with SAT_EN=0 -> acc=-16384 (0xC000), ovf=1.
//  - Stalls: len=2, prod_valid toggled 1,0,0,1 with prods 7,X,X,-9 -> acc=-2.
//    prod_valid in IDLE is ignored and prod_ready=0 there.
//  - len=4, start re-asserted after 2 accepts -> acc=0 and remaining=4.
//    Then 4 x prod=-1 -> acc=-4, exactly one done.
//  - rst_n low mid-run after 1 accept -> acc=0, busy=0, done=0 immediately.
//    No done pulse after release until a new start.

Source files
------------

// File: rtl/booth_mac_accumulator.sv
// Accumulates a programmed-length run of signed 16-bit Booth products into a signed ACC_W-bit sum,
// with either saturating or wrapping overflow handling and a sticky overflow flag.
module booth_mac_accumulator #(
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 4,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [15:0]       prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              done,
    output logic              busy,
    output logic              ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One extra bit so a zero length field can encode the full 2**LEN_W run.
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] remaining_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic [ACC_W:0]   sum_s;
    logic             sum_ovf_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] len_load_s;

    // Fit an ACC_W+1 bit sum back into ACC_W bits, clamping toward the true sign when enabled.
    function automatic logic [ACC_W-1:0] fit_sum(input logic [ACC_W:0] sum);
        logic [ACC_W-1:0] res;
        if ((sum[ACC_W] != sum[ACC_W-1]) && (SAT_EN != 0)) begin
            if (sum[ACC_W]) begin
                res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = sum[ACC_W-1:0];
        end
        return res;
    endfunction

    // Datapath: handshake qualification, widened sum and overflow detection.
    always_comb begin
        accept_s   = prod_valid & (state_r == ST_ACCUM) & ~start;
        sum_s      = {acc_r[ACC_W-1], acc_r} + {{(ACC_W-15){prod[15]}}, prod};
        sum_ovf_s  = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        acc_nxt_s  = fit_sum(sum_s);
        if (len == {LEN_W{1'b0}}) begin
            len_load_s = {1'b1, {LEN_W{1'b0}}};
        end else begin
            len_load_s = {1'b0, len};
        end
    end

    // Next-state logic; start overrides every state, including an in-flight run.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_ACCUM: begin
                    if (accept_s && (remaining_r == CNT_ONE)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus registered status flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_ACCUM);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Accumulator, run counter and sticky overflow; a start clears the run and drops any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {ACC_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
        end else if (start) begin
            acc_r       <= {ACC_W{1'b0}};
            remaining_r <= len_load_s;
            ovf_r       <= 1'b0;
        end else if (accept_s) begin
            acc_r       <= acc_nxt_s;
            remaining_r <= remaining_r - CNT_ONE;
            ovf_r       <= ovf_r | sum_ovf_s;
        end else begin
            acc_r       <= acc_r;
            remaining_r <= remaining_r;
            ovf_r       <= ovf_r;
        end
    end

    assign prod_ready = busy_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign acc        = acc_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: a 24-bit saturating instance plus 16-bit saturating
// and wrapping instances sharing the same stimulus for the overflow cases.
module tb_booth_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic [15:0] prod;
    logic        prod_valid;

    logic               m_ready, m_done, m_busy, m_ovf;
    logic signed [23:0] m_acc;
    logic               s_ready, s_done, s_busy, s_ovf;
    logic signed [15:0] s_acc;
    logic               w_ready, w_done, w_busy, w_ovf;
    logic signed [15:0] w_acc;

    int n_tests;
    int n_fail;
    int done_cnt;

    booth_mac_accumulator #(.ACC_W(24), .LEN_W(4), .SAT_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(m_ready), .acc(m_acc),
        .done(m_done), .busy(m_busy), .ovf(m_ovf)
    );

    booth_mac_accumulator #(.ACC_W(16), .LEN_W(4), .SAT_EN(1)) u_sat16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(s_ready), .acc(s_acc),
        .done(s_done), .busy(s_busy), .ovf(s_ovf)
    );

    booth_mac_accumulator #(.ACC_W(16), .LEN_W(4), .SAT_EN(0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(w_ready), .acc(w_acc),
        .done(w_done), .busy(w_busy), .ovf(w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] l);
        start      = 1'b1;
        len        = l;
        step();
        start      = 1'b0;
    endtask

    task automatic feed(input logic [15:0] p);
        prod_valid = 1'b1;
        prod       = p;
        step();
        prod_valid = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = 4'd0;
        prod       = 16'd0;
        prod_valid = 1'b0;
        step();
        step();
        check("rst_acc",   m_acc,   0);
        check("rst_busy",  m_busy,  0);
        check("rst_done",  m_done,  0);
        check("rst_ovf",   m_ovf,   0);
        check("rst_ready", m_ready, 0);
        rst_n = 1'b1;
        step();

        // Basic run of three back-to-back products.
        start_run(4'd3);
        check("t1_busy",  m_busy,  1);
        check("t1_ready", m_ready, 1);
        check("t1_acc0",  m_acc,   0);
        feed(16'sd100);
        check("t1_acc1", m_acc, 100);
        feed(-16'sd50);
        check("t1_acc2", m_acc, 50);
        feed(16'sd1000);
        check("t1_acc",   m_acc,  1050);
        check("t1_done",  m_done, 1);
        check("t1_busy2", m_busy, 0);
        check("t1_ovf",   m_ovf,  0);
        step();
        check("t1_done_pulse", m_done, 0);
        check("t1_hold",       m_acc,  1050);

        // len=0 encodes a 16-product run.
        start_run(4'd0);
        for (int i = 0; i < 15; i++) feed(16'sd16384);
        check("t2_early_done", m_done, 0);
        check("t2_busy15",     m_busy, 1);
        feed(16'sd16384);
        check("t2_acc",  m_acc,  262144);
        check("t2_done", m_done, 1);
        check("t2_ovf",  m_ovf,  0);
        step();

        // Overflow: saturate vs wrap at 16 bits, no overflow at 24 bits.
        start_run(4'd3);
        for (int i = 0; i < 3; i++) feed(16'sd16384);
        check("t3_sat_acc",  s_acc,  32767);
        check("t3_sat_ovf",  s_ovf,  1);
        check("t3_wrap_acc", w_acc,  -16384);
        check("t3_wrap_ovf", w_ovf,  1);
        check("t3_wide_acc", m_acc,  49152);
        check("t3_wide_ovf", m_ovf,  0);
        check("t3_sat_done", s_done, 1);
        step();
        check("t3_sat_sticky", s_ovf, 1);

        // prod_valid in IDLE is ignored.
        feed(16'sd5000);
        check("t4_idle_acc",   m_acc,   49152);
        check("t4_idle_ready", m_ready, 0);
        check("t4_idle_sovf",  s_ovf,   1);
        // Stalled run: valid 1,0,0,1.
        start_run(4'd2);
        check("t4_ovf_clr", s_ovf, 0);
        feed(16'sd7);
        prod = 16'hxxxx;
        step();
        step();
        check("t4_stall_acc",  m_acc,  7);
        check("t4_stall_busy", m_busy, 1);
        feed(-16'sd9);
        check("t4_acc",  m_acc,  -2);
        check("t4_done", m_done, 1);
        step();

        // Restart mid-run; handshake in the start cycle is discarded.
        start_run(4'd4);
        feed(16'sd10);
        feed(16'sd10);
        check("t5_pre", m_acc, 20);
        start      = 1'b1;
        len        = 4'd4;
        prod_valid = 1'b1;
        prod       = 16'sd10;
        step();
        start      = 1'b0;
        prod_valid = 1'b0;
        check("t5_restart_acc",  m_acc,  0);
        check("t5_restart_busy", m_busy, 1);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            feed(-16'sd1);
            if (m_done) done_cnt++;
            if (i == 3) check("t5_acc", m_acc, -4);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (m_done) done_cnt++;
        end
        check("t5_done_cnt", done_cnt, 1);

        // Reset in the middle of a run clears everything immediately.
        start_run(4'd3);
        feed(16'sd50);
        check("t6_pre", m_acc, 50);
        rst_n = 1'b0;
        #1;
        check("t6_acc",  m_acc,  0);
        check("t6_busy", m_busy, 0);
        check("t6_done", m_done, 0);
        step();
        rst_n      = 1'b1;
        prod_valid = 1'b1;
        prod       = 16'sd50;
        done_cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m_done) done_cnt++;
        end
        prod_valid = 1'b0;
        check("t6_no_done", done_cnt, 0);
        check("t6_idle_busy", m_busy, 0);
        check("t6_idle_acc",  m_acc,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
